// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: single-outstanding memory responder for the multicycle
// core. Requests are latched in IDLE, held for a programmable number of wait
// states, and the access (write commit / read capture) happens on the edge that
// enters RESP, where a one-cycle resp_valid pulse is produced.
module riscv_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic [31:0] resp_rdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    localparam int          DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Latched request; only meaningful while busy, so it carries no reset.
    logic        re_q, we_q, uns_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;

    logic [31:0] mem [DEPTH];

    // Access view: in IDLE (zero-wait case) the live request is used directly,
    // otherwise the latched copy.
    logic                  idle, enter_resp, wr_en;
    logic                  acc_re, acc_we, acc_uns, acc_err;
    logic [31:0]           acc_addr, acc_wdata;
    logic [1:0]            acc_size;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [3:0]            acc_be;
    logic [31:0]           wr_word, rd_word, rd_shift, rd_ext;

    // State register and response registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request fields when a new transaction is accepted.
    always_ff @(posedge clk) begin
        if (idle && (req_re || req_we)) begin
            re_q    <= req_re;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
        end
    end

    // Next-state logic: IDLE -> WAIT (counting down) -> RESP -> IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_re || req_we) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Access decode: error checks, byte enables, write-lane replication, read extension.
    always_comb begin
        idle      = (state_q == S_IDLE);
        acc_re    = idle ? req_re       : re_q;
        acc_we    = idle ? req_we       : we_q;
        acc_addr  = idle ? req_addr     : addr_q;
        acc_wdata = idle ? req_wdata    : wdata_q;
        acc_size  = idle ? req_size     : size_q;
        acc_uns   = idle ? req_unsigned : uns_q;
        acc_idx   = acc_addr[ADDR_WIDTH+1:2];

        acc_err = (acc_re && acc_we)
                || (acc_size == 2'b11)
                || (acc_size == 2'b01 && acc_addr[0])
                || (acc_size == 2'b10 && acc_addr[1:0] != 2'b00)
                || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);

        case (acc_size)
            2'b00:   acc_be = 4'b0001 << acc_addr[1:0];
            2'b01:   acc_be = acc_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   acc_be = 4'b1111;
            default: acc_be = 4'b0000;
        endcase

        case (acc_size)
            2'b00:   wr_word = {4{acc_wdata[7:0]}};
            2'b01:   wr_word = {2{acc_wdata[15:0]}};
            default: wr_word = acc_wdata;
        endcase

        rd_word  = mem[acc_idx];
        rd_shift = rd_word >> {acc_addr[1:0], 3'b000};
        case (acc_size)
            2'b00:   rd_ext = acc_uns ? {24'd0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = acc_uns ? {16'd0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_word;
        endcase

        // Gating with reset keeps a write from committing while reset is held.
        wr_en   = enter_resp && acc_we && !acc_err && reset;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_err || !acc_re) ? 32'd0 : rd_ext;
        end
    end

    // Storage: byte-lane writes, no reset of contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = rdata_q;
    assign busy       = !idle;

endmodule
